// File: rtl/completion_buffer.sv
// completion_buffer: in-order retirement buffer; entries are allocated at dispatch,
// completed out of order by two functional units, and retired to the register file in allocation order.
module completion_buffer #(
  parameter int NUM_CB_ENTRY = 8,
  parameter int WORD_W = 32,
  localparam int IDX = $clog2(NUM_CB_ENTRY)
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              alloc_req,
  input  logic [4:0]        alloc_rd,
  output logic [IDX-1:0]    alloc_idx,
  output logic              full,
  output logic              empty,
  output logic [IDX:0]      count,
  input  logic              done_a,
  input  logic [IDX-1:0]    index_a,
  input  logic [WORD_W-1:0] wdata_a,
  input  logic              wen_a,
  input  logic              done_b,
  input  logic [IDX-1:0]    index_b,
  input  logic [WORD_W-1:0] wdata_b,
  input  logic              wen_b,
  input  logic              flush,
  output logic              commit_valid,
  output logic              rf_wen,
  output logic [4:0]        rf_rd,
  output logic [WORD_W-1:0] rf_wdata
);
  localparam logic [IDX:0] FULL_CNT = NUM_CB_ENTRY[IDX:0];
  logic [NUM_CB_ENTRY-1:0] valid_q, ready_q, wen_q;
  logic [4:0]              rd_q   [NUM_CB_ENTRY];
  logic [WORD_W-1:0]       data_q [NUM_CB_ENTRY];
  logic [IDX-1:0]          head_q, head_d, tail_q, tail_d;
  logic [IDX:0]            count_q, count_d;
  logic                    alloc_ok;
  always_comb begin
    full         = count_q == FULL_CNT;
    empty        = count_q == '0;
    count        = count_q;
    alloc_idx    = tail_q;
    commit_valid = valid_q[head_q] & ready_q[head_q] & ~flush;
    rf_wen       = commit_valid & wen_q[head_q] & (rd_q[head_q] != 5'd0);
    rf_rd        = commit_valid ? rd_q[head_q] : 5'd0;
    rf_wdata     = commit_valid ? data_q[head_q] : '0;
    alloc_ok     = alloc_req & ~full & ~flush;
    head_d       = head_q + IDX'(commit_valid);
    tail_d       = tail_q + IDX'(alloc_ok);
    count_d      = count_q + (IDX+1)'(alloc_ok) - (IDX+1)'(commit_valid);
  end
  // Later non-blocking writes win: port a overrides port b, commit clears a
  // same-cycle completion on the head, and allocation initialises its entry last.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q <= '0;
      ready_q <= '0;
      wen_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < NUM_CB_ENTRY; i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else if (flush) begin
      valid_q <= '0;
      ready_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (done_b && valid_q[index_b]) begin
        ready_q[index_b] <= 1'b1;
        data_q[index_b]  <= wdata_b;
        wen_q[index_b]   <= wen_b;
      end
      if (done_a && valid_q[index_a]) begin
        ready_q[index_a] <= 1'b1;
        data_q[index_a]  <= wdata_a;
        wen_q[index_a]   <= wen_a;
      end
      if (commit_valid) begin
        valid_q[head_q] <= 1'b0;
        ready_q[head_q] <= 1'b0;
      end
      if (alloc_ok) begin
        valid_q[tail_q] <= 1'b1;
        ready_q[tail_q] <= 1'b0;
        wen_q[tail_q]   <= 1'b0;
        rd_q[tail_q]    <= alloc_rd;
      end
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
endmodule

// File: tb/tb_completion_buffer.sv
// tb_completion_buffer: directed steps with a commit scoreboard for completion_buffer.
module tb_completion_buffer;
  localparam int N = 8;
  localparam int W = 32;
  localparam int IDX = 3;
  typedef struct packed {logic [4:0] rd; logic wen; logic [W-1:0] data;} exp_t;
  logic CLK = 1'b0;
  logic nRST, alloc_req, done_a, wen_a, done_b, wen_b, flush;
  logic [4:0] alloc_rd;
  logic [IDX-1:0] alloc_idx, index_a, index_b;
  logic [W-1:0] wdata_a, wdata_b, rf_wdata;
  logic full, empty, commit_valid, rf_wen;
  logic [IDX:0] count;
  logic [4:0] rf_rd;
  exp_t sb[$];
  exp_t e;
  int compared = 0;
  int mismatched = 0;
  completion_buffer #(.NUM_CB_ENTRY(N), .WORD_W(W)) dut (
    .CLK(CLK), .nRST(nRST), .alloc_req(alloc_req), .alloc_rd(alloc_rd),
    .alloc_idx(alloc_idx), .full(full), .empty(empty), .count(count),
    .done_a(done_a), .index_a(index_a), .wdata_a(wdata_a), .wen_a(wen_a),
    .done_b(done_b), .index_b(index_b), .wdata_b(wdata_b), .wen_b(wen_b),
    .flush(flush), .commit_valid(commit_valid), .rf_wen(rf_wen),
    .rf_rd(rf_rd), .rf_wdata(rf_wdata)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    compared++;
    assert (obs === exp_v) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask
  always @(negedge CLK) begin
    if (commit_valid) begin
      chk("commit_pending", {63'd0, sb.size() != 0}, 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("commit_rd", 64'(rf_rd), 64'(e.rd));
        chk("commit_wen", 64'(rf_wen), 64'(e.wen));
        chk("commit_data", 64'(rf_wdata), 64'(e.data));
      end
    end
  end
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask
  task automatic alloc(input logic [4:0] rd, input logic [IDX-1:0] idx);
    alloc_req = 1'b1;
    alloc_rd = rd;
    chk("alloc_idx", 64'(alloc_idx), 64'(idx));
    cyc();
    alloc_req = 1'b0;
  endtask
  task automatic comp_a(input logic [IDX-1:0] idx, input logic [W-1:0] d, input logic we);
    done_a = 1'b1; index_a = idx; wdata_a = d; wen_a = we;
    cyc();
    done_a = 1'b0;
  endtask
  task automatic comp_b(input logic [IDX-1:0] idx, input logic [W-1:0] d, input logic we);
    done_b = 1'b1; index_b = idx; wdata_b = d; wen_b = we;
    cyc();
    done_b = 1'b0;
  endtask
  initial begin
    nRST = 1'b0; alloc_req = 1'b0; alloc_rd = '0; flush = 1'b0;
    done_a = 1'b0; index_a = '0; wdata_a = '0; wen_a = 1'b0;
    done_b = 1'b0; index_b = '0; wdata_b = '0; wen_b = 1'b0;
    @(negedge CLK);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_alloc_idx", 64'(alloc_idx), 64'd0);
    chk("rst_commit", 64'(commit_valid), 64'd0);
    chk("rst_rf", {26'd0, rf_wen, rf_rd, rf_wdata}, 64'd0);
    cyc();
    nRST = 1'b1;
    // out-of-order completion, in-order retirement
    alloc(5'd5, 3'd0);
    alloc(5'd6, 3'd1);
    alloc(5'd7, 3'd2);
    chk("t1_count", 64'(count), 64'd3);
    comp_a(3'd1, 32'h11, 1'b1);
    chk("t1_no_commit", 64'(commit_valid), 64'd0);
    sb.push_back('{5'd5, 1'b1, 32'h22});
    sb.push_back('{5'd6, 1'b1, 32'h11});
    comp_b(3'd0, 32'h22, 1'b1);
    chk("t1_cv", 64'(commit_valid), 64'd1);
    cyc();
    cyc();
    cyc();
    chk("t1_rd7_wait", 64'(commit_valid), 64'd0);
    chk("t1_count1", 64'(count), 64'd1);
    sb.push_back('{5'd7, 1'b1, 32'h33});
    comp_a(3'd2, 32'h33, 1'b1);
    cyc();
    chk("t1_empty", 64'(empty), 64'd1);
    nRST = 1'b0;
    #1;
    chk("async_rst_idx", 64'(alloc_idx), 64'd0);
    nRST = 1'b1;
    // fill, drop overflow, drain with wrap
    for (int i = 0; i < N; i++) alloc(5'(8 + i), 3'(i));
    chk("t2_full", 64'(full), 64'd1);
    chk("t2_count", 64'(count), 64'd8);
    alloc_req = 1'b1;
    alloc_rd = 5'd1;
    cyc();
    alloc_req = 1'b0;
    chk("t2_drop_count", 64'(count), 64'd8);
    chk("t2_drop_tail", 64'(alloc_idx), 64'd0);
    for (int i = 0; i < N; i++) begin
      sb.push_back('{5'(8 + i), 1'b1, 32'(i * 257 + 1)});
      comp_a(3'(i), 32'(i * 257 + 1), 1'b1);
    end
    cyc();
    chk("t2_empty", 64'(empty), 64'd1);
    chk("t2_tail_wrap", 64'(alloc_idx), 64'd0);
    // rd=0 suppresses the register-file write
    alloc(5'd0, 3'd0);
    sb.push_back('{5'd0, 1'b0, 32'hDEAD});
    comp_a(3'd0, 32'hDEAD, 1'b1);
    chk("t3_cv", 64'(commit_valid), 64'd1);
    chk("t3_rf_wen", 64'(rf_wen), 64'd0);
    cyc();
    chk("t3_empty", 64'(empty), 64'd1);
    // dual completion on one index, completion of an unallocated index
    alloc(5'd1, 3'd1);
    alloc(5'd2, 3'd2);
    alloc(5'd3, 3'd3);
    done_a = 1'b1; index_a = 3'd3; wdata_a = 32'hAAAA; wen_a = 1'b1;
    done_b = 1'b1; index_b = 3'd3; wdata_b = 32'hBBBB; wen_b = 1'b1;
    cyc();
    done_a = 1'b0; done_b = 1'b0;
    chk("t4_no_commit", 64'(commit_valid), 64'd0);
    comp_a(3'd5, 32'h5555, 1'b1);
    chk("t4_count", 64'(count), 64'd3);
    chk("t4_tail", 64'(alloc_idx), 64'd4);
    chk("t4_no_commit2", 64'(commit_valid), 64'd0);
    sb.push_back('{5'd1, 1'b1, 32'h101});
    sb.push_back('{5'd2, 1'b1, 32'h202});
    sb.push_back('{5'd3, 1'b1, 32'hAAAA});
    comp_a(3'd1, 32'h101, 1'b1);
    comp_b(3'd2, 32'h202, 1'b1);
    cyc();
    cyc();
    chk("t4_empty", 64'(empty), 64'd1);
    // full buffer: commit proceeds, same-cycle alloc refused
    nRST = 1'b0;
    #1;
    nRST = 1'b1;
    for (int i = 0; i < N; i++) alloc(5'(20 + i), 3'(i));
    sb.push_back('{5'd20, 1'b1, 32'h44});
    comp_a(3'd0, 32'h44, 1'b1);
    chk("t5_full", 64'(full), 64'd1);
    chk("t5_cv", 64'(commit_valid), 64'd1);
    alloc_req = 1'b1;
    alloc_rd = 5'd31;
    cyc();
    alloc_req = 1'b0;
    chk("t5_count7", 64'(count), 64'd7);
    chk("t5_full0", 64'(full), 64'd0);
    alloc(5'd31, 3'd0);
    chk("t5_count8", 64'(count), 64'd8);
    // reset while the head is committing
    comp_a(3'd1, 32'h55, 1'b1);
    nRST = 1'b0;
    #1;
    chk("mid_rst_cv", 64'(commit_valid), 64'd0);
    chk("mid_rst_rf", {26'd0, rf_wen, rf_rd, rf_wdata}, 64'd0);
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_full", 64'(full), 64'd0);
    chk("mid_rst_empty", 64'(empty), 64'd1);
    @(negedge CLK);
    nRST = 1'b1;
    cyc();
    // flush beats alloc and completion
    for (int i = 0; i < 4; i++) alloc(5'(10 + i), 3'(i));
    comp_a(3'd1, 32'h1, 1'b1);
    comp_b(3'd2, 32'h2, 1'b1);
    chk("t6_count4", 64'(count), 64'd4);
    flush = 1'b1; alloc_req = 1'b1; alloc_rd = 5'd9;
    done_a = 1'b1; index_a = 3'd0; wdata_a = 32'h99; wen_a = 1'b1;
    chk("t6_cv_flush", 64'(commit_valid), 64'd0);
    cyc();
    flush = 1'b0; alloc_req = 1'b0; done_a = 1'b0;
    chk("t6_count0", 64'(count), 64'd0);
    chk("t6_empty", 64'(empty), 64'd1);
    chk("t6_alloc_idx", 64'(alloc_idx), 64'd0);
    cyc();
    chk("t6_no_commit", 64'(commit_valid), 64'd0);
    alloc(5'd14, 3'd0);
    comp_a(3'd0, 32'h7, 1'b1);
    flush = 1'b1;
    #1;
    chk("t6_flush_masks_cv", 64'(commit_valid), 64'd0);
    chk("t6_flush_masks_wen", 64'(rf_wen), 64'd0);
    cyc();
    flush = 1'b0;
    chk("t6_empty2", 64'(empty), 64'd1);
    cyc();
    cyc();
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/completion_buffer.md
Name: completion_buffer

Overview:
- In-order retirement buffer on the receiving end of the arithmetic-unit writeback interface.
- Dispatch allocates an entry and passes its index to the functional unit.
- Functional units report completion by index (done_a/index_a from the arithmetic unit, done_b/index_b from a second unit).
- The buffer retires completed results to the register file strictly in allocation order, one per cycle.

Parameters:
- NUM_CB_ENTRY, 8: number of entries. Must be a power of two, at least 2. IDX = $clog2(NUM_CB_ENTRY).
- WORD_W, 32: result data width.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- alloc_req  in  1  dispatch requests an entry.
- alloc_rd  in  5  destination register of the allocating instruction.
- alloc_idx  out  IDX  index that will be assigned (current tail).
- full  out  1  no free entry.
- empty  out  1  no valid entry.
- count  out  IDX+1  number of valid entries.
- done_a  in  1  arithmetic unit completion strobe.
- index_a  in  IDX  entry completed by the arithmetic unit.
- wdata_a  in  WORD_W  result from the arithmetic unit.
- wen_a  in  1  result is to be written.
- done_b  in  1  second-unit completion strobe.
- index_b  in  IDX  entry completed by the second unit.
- wdata_b  in  WORD_W  result from the second unit.
- wen_b  in  1  result is to be written.
- flush  in  1  discard all entries.
- commit_valid  out  1  head entry retires this cycle.
- rf_wen  out  1  register-file write enable.
- rf_rd  out  5  register-file destination.
- rf_wdata  out  WORD_W  register-file write data.

Behaviour:
- Storage per entry: valid, ready, wen, rd[4:0], data. Head and tail pointers are IDX bits wide and wrap modulo NUM_CB_ENTRY. count is held as a register.
- Reset (nRST low, asynchronous): all valid/ready bits cleared; head=tail=0; count=0. Outputs: full=0, empty=1, alloc_idx=0, commit_valid=0, rf_wen=0, rf_rd=0, rf_wdata=0.
- Reset asserted mid-operation discards all entries. No commit occurs in that cycle.
- Allocation: accepted at a rising edge when alloc_req=1, full=0 and flush=0.
  - Entry[tail] becomes valid=1, ready=0, wen=0, rd=alloc_rd.
  - tail increments.
  - alloc_idx shows the index in the same cycle the request is presented.
  - alloc_req while full is dropped. Dispatch must stall on full.
- Completion: at an edge with done_x=1 and entry[index_x].valid=1:
  - ready is set to 1.
  - data is set to wdata_x.
  - wen is set to wen_x.
  - done_x targeting an invalid entry is ignored with no state change.
  - done_a and done_b naming the same index in one cycle: port a wins.
  - Completion on an already-ready entry overwrites the stored data.
- Commit (combinational from registered state):
  - commit_valid = entry[head].valid & entry[head].ready & ~flush.
  - When commit_valid=1: rf_wen = entry wen & (rd != 0), rf_rd = entry rd, rf_wdata = entry data. Otherwise all three are 0.
  - On the edge with commit_valid=1, the entry is invalidated and head increments.
  - Latency: a completion registered at edge N is committed in the cycle after edge N, at the earliest, if that entry is at the head.
- Simultaneous events in one cycle:
  - Commit and allocate: count is unchanged; both pointers advance.
  - full is evaluated on registered state, so an allocation is refused when full even if a commit occurs in the same cycle.
  - A completion may target the head entry in the same cycle it would otherwise commit. It is not committed until the following cycle.
- Flush: highest priority.
  - At the edge, all valid/ready bits are cleared; head=tail=0; count=0.
  - Allocation and completions presented in the same cycle are ignored.
  - commit_valid is forced to 0 during flush.
- Status: full = (count == NUM_CB_ENTRY); empty = (count == 0).

Test Plan:
- Reset, then allocate rd=5,6,7 (idx 0,1,2). Complete idx 1 via port a with 0x11, then idx 0 via port b with 0x22. Required: commit rd=5 data 0x22, then rd=6 data 0x11. Nothing commits for rd=7 until it completes.
- Allocate 8 entries. Required: full=1, count=8. A 9th alloc_req is dropped and tail stays 0. Complete and commit all 8. Required: head wraps to 0, empty=1.
- Allocate with rd=0 and complete with wen_a=1 and data 0xDEAD. Required: commit_valid=1, rf_wen=0.
- done_a and done_b both on idx 3, with data 0xAAAA and 0xBBBB. Required: the stored data is 0xAAAA. done_a on an unallocated idx 5 leaves state unchanged.
- With the buffer full and the head ready, present alloc_req. Required: the commit occurs, the alloc is refused, count goes 8 to 7. Alloc on the next cycle succeeds at idx 0.
- With 4 entries valid and 2 ready, assert flush together with alloc_req and done_a. Required: count=0, empty=1, no commit, alloc_idx=0 next cycle. Assert nRST low mid-sequence. Required: outputs return to reset values immediately.
